// File: rtl/bloom_pkg.sv
// ============================================================================
// bloom_pkg : notation codes, scan FSM states and packed peak field offsets
// Rev 1.0
// ============================================================================
`default_nettype none

package bloom_pkg;

    localparam logic [1:0] NOT_NORMAL  = 2'b00;
    localparam logic [1:0] NOT_STRONG  = 2'b01;
    localparam logic [1:0] NOT_BLOOM   = 2'b10;
    localparam logic [1:0] NOT_INVALID = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } scan_state_t;

    // Each peak field is {signal, distance}; distance sits in the low bits.
    function automatic int peak_dist_lsb(input int idx, input int sig_w, input int dist_w);
        return idx * (sig_w + dist_w);
    endfunction

    function automatic int peak_sig_lsb(input int idx, input int sig_w, input int dist_w);
        return idx * (sig_w + dist_w) + dist_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bloom_point_classify.sv
// ============================================================================
// bloom_point_classify : unpacks one point and decides its 2-bit notation
// Rev 1.0
// ============================================================================
`default_nettype none

module bloom_point_classify
    import bloom_pkg::*;
#(
    parameter int                      SIGNAL_WIDTH = 18,
    parameter int                      DIST_WIDTH   = 14,
    parameter int                      NOT_WIDTH    = 2,
    parameter int                      PEAK_NUM     = 4,
    parameter int                      DATA_WIDTH   = (SIGNAL_WIDTH + DIST_WIDTH) * PEAK_NUM,
    parameter logic [SIGNAL_WIDTH-1:0] SAT_THRESH   = 18'h3FF00,
    parameter int                      DIST_TOL     = 4
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  window_active,
    input  logic [DIST_WIDTH-1:0] strong_dist,
    output logic [NOT_WIDTH-1:0]  notation,
    output logic [DIST_WIDTH-1:0] new_strong_dist
);

    localparam logic [DIST_WIDTH:0] c_dist_tol = (DIST_WIDTH + 1)'(DIST_TOL);

    logic [SIGNAL_WIDTH-1:0] w_sig  [PEAK_NUM];
    logic [DIST_WIDTH-1:0]   w_dist [PEAK_NUM];
    logic [DIST_WIDTH:0]     w_diff [PEAK_NUM];

    logic [SIGNAL_WIDTH-1:0] w_best_sig;
    logic [DIST_WIDTH-1:0]   w_best_dist;
    logic                    w_any_sig;
    logic                    w_near;

    // One extra bit keeps the absolute distance difference from wrapping.
    for (genvar g = 0; g < PEAK_NUM; g++) begin : g_unpack
        assign w_sig[g]  = data[peak_sig_lsb(g, SIGNAL_WIDTH, DIST_WIDTH) +: SIGNAL_WIDTH];
        assign w_dist[g] = data[peak_dist_lsb(g, SIGNAL_WIDTH, DIST_WIDTH) +: DIST_WIDTH];
        assign w_diff[g] = (w_dist[g] >= strong_dist)
                         ? ({1'b0, w_dist[g]} - {1'b0, strong_dist})
                         : ({1'b0, strong_dist} - {1'b0, w_dist[g]});
    end

    // Strict '>' keeps the lowest index on equal signals.
    always_comb begin
        w_best_sig  = w_sig[0];
        w_best_dist = w_dist[0];
        w_any_sig   = 1'b0;
        w_near      = 1'b0;
        for (int i = 0; i < PEAK_NUM; i++) begin
            if (w_sig[i] > w_best_sig) begin
                w_best_sig  = w_sig[i];
                w_best_dist = w_dist[i];
            end
            if (w_sig[i] != '0) begin
                w_any_sig = 1'b1;
                if (w_diff[i] <= c_dist_tol) begin
                    w_near = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (!w_any_sig) begin
            notation = NOT_WIDTH'(NOT_INVALID);
        end else if (w_best_sig >= SAT_THRESH) begin
            notation = NOT_WIDTH'(NOT_STRONG);
        end else if (window_active && w_near) begin
            notation = NOT_WIDTH'(NOT_BLOOM);
        end else begin
            notation = NOT_WIDTH'(NOT_NORMAL);
        end
    end

    assign new_strong_dist = w_best_dist;

endmodule

`default_nettype wire

// File: rtl/bloom_scan_ctrl.sv
// ============================================================================
// bloom_scan_ctrl : sequences one pass over the point memory and writes back
//                   a notation per point; optional stats via BLOOM_SCAN_STATS_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module bloom_scan_ctrl
    import bloom_pkg::*;
#(
    parameter int                      SIGNAL_WIDTH = 18,
    parameter int                      DIST_WIDTH   = 14,
    parameter int                      NOT_WIDTH    = 2,
    parameter int                      PEAK_NUM     = 4,
    parameter int                      DATA_WIDTH   = (SIGNAL_WIDTH + DIST_WIDTH) * PEAK_NUM,
    parameter int                      ADDR_WIDTH   = 5,
    parameter int                      MEM_LEN      = 30,
    parameter logic [SIGNAL_WIDTH-1:0] SAT_THRESH   = 18'h3FF00,
    parameter int                      DIST_TOL     = 4,
    parameter int                      BLOOM_WIN    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  wr_en,
    output logic [NOT_WIDTH-1:0]  point_notation,
    output logic                  busy,
    output logic                  bloom_end
`ifdef BLOOM_SCAN_STATS_EN
    ,
    output logic [ADDR_WIDTH:0]   strong_cnt,
    output logic [ADDR_WIDTH:0]   bloom_cnt
`endif
);

    localparam int                  WIN_W       = (BLOOM_WIN < 1) ? 1 : $clog2(BLOOM_WIN + 1);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(MEM_LEN - 1);
    localparam logic [WIN_W-1:0]    c_win_load  = WIN_W'(BLOOM_WIN);

    scan_state_t            r_state;
    logic [ADDR_WIDTH-1:0]  r_rd_idx;
    logic [WIN_W-1:0]       r_window;
    logic [DIST_WIDTH-1:0]  r_strong_dist;

    logic [ADDR_WIDTH-1:0]  w_addr_next;
    logic [NOT_WIDTH-1:0]   w_class;
    logic [DIST_WIDTH-1:0]  w_new_strong_dist;
    logic                   w_is_strong;

    bloom_point_classify #(
        .SIGNAL_WIDTH (SIGNAL_WIDTH),
        .DIST_WIDTH   (DIST_WIDTH),
        .NOT_WIDTH    (NOT_WIDTH),
        .PEAK_NUM     (PEAK_NUM),
        .DATA_WIDTH   (DATA_WIDTH),
        .SAT_THRESH   (SAT_THRESH),
        .DIST_TOL     (DIST_TOL)
    ) u_classify (
        .data            (mem_data),
        .window_active   (r_window != '0),
        .strong_dist     (r_strong_dist),
        .notation        (w_class),
        .new_strong_dist (w_new_strong_dist)
    );

    assign w_addr_next    = (addr == c_last_addr) ? addr : addr + 1'b1;
    assign w_is_strong    = (w_class == NOT_WIDTH'(NOT_STRONG));
    assign point_notation = (r_state == ST_SCAN) ? w_class : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            addr          <= '0;
            r_rd_idx      <= '0;
            wr_en         <= 1'b0;
            busy          <= 1'b0;
            bloom_end     <= 1'b0;
            r_window      <= '0;
            r_strong_dist <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state       <= ST_FILL;
                        addr          <= '0;
                        busy          <= 1'b1;
                        bloom_end     <= 1'b0;
                        r_window      <= '0;
                        r_strong_dist <= '0;
                    end
                end
                ST_FILL: begin
                    r_state  <= ST_SCAN;
                    addr     <= w_addr_next;
                    r_rd_idx <= addr;
                    wr_en    <= 1'b1;
                end
                ST_SCAN: begin
                    addr     <= w_addr_next;
                    r_rd_idx <= addr;
                    // A strong point reloads the window instead of decrementing it.
                    if (w_is_strong) begin
                        r_window      <= c_win_load;
                        r_strong_dist <= w_new_strong_dist;
                    end else if (r_window != '0) begin
                        r_window <= r_window - 1'b1;
                    end
                    if (r_rd_idx == c_last_addr) begin
                        r_state   <= ST_DONE;
                        wr_en     <= 1'b0;
                        busy      <= 1'b0;
                        bloom_end <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BLOOM_SCAN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            strong_cnt <= '0;
            bloom_cnt  <= '0;
        end else if (r_state == ST_IDLE && start) begin
            strong_cnt <= '0;
            bloom_cnt  <= '0;
        end else if (r_state == ST_SCAN) begin
            if (w_is_strong) begin
                strong_cnt <= strong_cnt + 1'b1;
            end
            if (w_class == NOT_WIDTH'(NOT_BLOOM)) begin
                bloom_cnt <= bloom_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
